// File: rtl/bcd_seq_adder.sv
// Multi-byte packed-BCD add/subtract engine: one byte per clock, LSB byte first,
// decimal carry/borrow rippled between bytes through a register.
module bcd_seq_adder #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   carry_in,
  input  logic [8*NUM_BYTES-1:0] a,
  input  logic [8*NUM_BYTES-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   carry_out,
  output logic                   zero,
  output logic                   invalid
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // {carry_out, byte} of a decimal-adjusted byte addition
  function automatic logic [8:0] daa_add(input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
    logic [8:0] s;
    logic       h, lo6, hi6;
    logic [7:0] adj;
    s   = {1'b0, x} + {1'b0, y} + {8'd0, c};
    h   = ({1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, c}) > 5'd15;
    lo6 = h | (s[3:0] > 4'd9);
    hi6 = s[8] | (s[7:0] > 8'h99);
    adj = s[7:0] + (lo6 ? 8'h06 : 8'h00) + (hi6 ? 8'h60 : 8'h00);
    return {hi6, adj};
  endfunction

  // {borrow_out, byte} of a decimal-adjusted byte subtraction
  function automatic logic [8:0] daa_sub(input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
    logic [7:0] d;
    logic       bw, hb;
    logic [7:0] adj;
    d   = x - y - {7'd0, c};
    bw  = {1'b0, x} < ({1'b0, y} + {8'd0, c});
    hb  = {1'b0, x[3:0]} < ({1'b0, y[3:0]} + {4'd0, c});
    adj = d - (hb ? 8'h06 : 8'h00) - (bw ? 8'h60 : 8'h00);
    return {bw, adj};
  endfunction

  function automatic logic has_bad_nibble(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 2 * NUM_BYTES; i++) bad = bad | (v[4*i +: 4] > 4'd9);
    return bad;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             sub_q, sub_d, cy_q, cy_d, inv_q, inv_d;
  logic             done_q, done_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_out_q, carry_out_d, zero_q, zero_d, invalid_q, invalid_d;
  logic [7:0]       x_byte, y_byte;
  logic [8:0]       byte_res;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sub_d       = sub_q;
    cy_d        = cy_q;
    inv_d       = inv_q;
    done_d      = 1'b0;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    invalid_d   = invalid_q;
    x_byte      = a_q[8*idx_q +: 8];
    y_byte      = b_q[8*idx_q +: 8];
    byte_res    = sub_q ? daa_sub(x_byte, y_byte, cy_q) : daa_add(x_byte, y_byte, cy_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          cy_d    = carry_in;
          inv_d   = has_bad_nibble(a) | has_bad_nibble(b);
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[8*idx_q +: 8] = byte_res[7:0];
        cy_d  = byte_res[8];
        idx_d = idx_q + 1'b1;
        // Last byte: publish the complete result and flags together
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = IDLE;
          done_d      = 1'b1;
          result_d    = acc_d;
          carry_out_d = byte_res[8];
          zero_d      = (acc_d == '0);
          invalid_d   = inv_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sub_q       <= 1'b0;
      cy_q        <= 1'b0;
      inv_q       <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sub_q       <= sub_d;
      cy_q        <= cy_d;
      inv_q       <= inv_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      invalid_q   <= invalid_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
  assign invalid   = invalid_q;

endmodule
